sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO that replaces the fixed 32x1024 buffer. It adds configurable data width and depth, and exact full/empty from a correctly sized occupancy counter. It also provides programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It sits between producer and consumer blocks in the same clock domain.

---
 rtl/sync_fifo_param.sv | 114 +++++++++++
 tb/tb_sync_fifo_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with FWFT option and sticky error flags
module sync_fifo_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter bit FWFT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              rd_acc;
    logic              wr_acc;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // A write into a full FIFO is still accepted when a read frees a slot the same edge.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // Storage has no reset; stale words are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & ~wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en & ~rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented directly from storage; rd_en acts as the pop.
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem[rd_ptr];
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed vector bench for sync_fifo_param (standard and FWFT instances)
module tb_sync_fifo_param;

    localparam int DW  = 32;
    localparam int DEP = 8;
    localparam int AFL = 4;
    localparam int AEL = 2;

    typedef struct {
        logic          wr_en;
        logic [DW-1:0] wr_data;
        logic          rd_en;
        logic          clr_err;
        logic [3:0]    count;
        logic          rv;
        logic [DW-1:0] rdd;
        logic          ovf;
        logic          udf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, rd_en, clr_err;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid, empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0]    count;

    logic          f_wr_en, f_rd_en, f_clr_err;
    logic [DW-1:0] f_wr_data;
    logic [DW-1:0] f_rd_data;
    logic          f_rd_valid, f_empty, f_full, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0]    f_count;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty), .full(f_full),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int we, input int wd, input int re, input int ce,
                                input int cnt, input int rv, input int rdd, input int ovf, input int udf);
        vec_t v;
        v.wr_en   = 1'(we);
        v.wr_data = DW'(wd);
        v.rd_en   = 1'(re);
        v.clr_err = 1'(ce);
        v.count   = 4'(cnt);
        v.rv      = 1'(rv);
        v.rdd     = DW'(rdd);
        v.ovf     = 1'(ovf);
        v.udf     = 1'(udf);
        return v;
    endfunction

    function automatic void add(input int we, input int wd, input int re, input int ce,
                                input int cnt, input int rv, input int rdd, input int ovf, input int udf);
        vecs.push_back(mk(we, wd, re, ce, cnt, rv, rdd, ovf, udf));
    endfunction

    // Drive one cycle of inputs, then check every output just after the edge.
    task automatic step(input vec_t v, input string tag);
        wr_en   = v.wr_en;
        wr_data = v.wr_data;
        rd_en   = v.rd_en;
        clr_err = v.clr_err;
        @(posedge clk);
        #1;
        chk({tag, ".count"}, DW'(count), DW'(v.count));
        chk({tag, ".rd_valid"}, DW'(rd_valid), DW'(v.rv));
        chk({tag, ".rd_data"}, rd_data, v.rdd);
        chk({tag, ".overflow"}, DW'(overflow), DW'(v.ovf));
        chk({tag, ".underflow"}, DW'(underflow), DW'(v.udf));
        chk({tag, ".empty"}, DW'(empty), DW'(v.count == 0));
        chk({tag, ".full"}, DW'(full), DW'(v.count == 4'(DEP)));
        chk({tag, ".almost_full"}, DW'(almost_full), DW'(v.count >= 4'(AFL)));
        chk({tag, ".almost_empty"}, DW'(almost_empty), DW'(v.count <= 4'(AEL)));
    endtask

    task automatic fstep(input int we, input int wd, input int re);
        f_wr_en   = 1'(we);
        f_wr_data = DW'(wd);
        f_rd_en   = 1'(re);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wr_data = '0;

        // Standard-mode table: basic order, empty corners, fill/overflow, wrap, drain.
        add(1, 32'h1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 32'h2, 0, 0, 2, 0, 0, 0, 0);
        add(1, 32'h3, 0, 0, 3, 0, 0, 0, 0);
        add(1, 32'h4, 0, 0, 4, 0, 0, 0, 0);
        add(0, 0, 1, 0, 3, 1, 32'h1, 0, 0);
        add(0, 0, 1, 0, 2, 1, 32'h2, 0, 0);
        add(0, 0, 1, 0, 1, 1, 32'h3, 0, 0);
        add(0, 0, 1, 0, 0, 1, 32'h4, 0, 0);
        add(0, 0, 0, 0, 0, 0, 32'h4, 0, 0);
        add(0, 0, 1, 0, 0, 0, 32'h4, 0, 1);
        add(1, 32'h5, 1, 0, 1, 0, 32'h4, 0, 1);
        add(0, 0, 0, 1, 1, 0, 32'h4, 0, 0);
        add(0, 0, 1, 0, 0, 1, 32'h5, 0, 0);
        for (int i = 0; i < DEP; i++) add(1, 32'h10 + i, 0, 0, i + 1, 0, 32'h5, 0, 0);
        add(1, 32'h99, 0, 0, 8, 0, 32'h5, 1, 0);
        add(0, 0, 0, 0, 8, 0, 32'h5, 1, 0);
        add(0, 0, 0, 1, 8, 0, 32'h5, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 32'h20 + i, 1, 0, 8, 1, 32'h10 + i, 0, 0);
        for (int i = 0; i < DEP; i++)
            add(0, 0, 1, 0, 7 - i, 1, (i < 5) ? (32'h13 + i) : (32'h20 + i - 5), 0, 0);
        add(0, 0, 1, 1, 0, 0, 32'h22, 0, 0);

        @(posedge clk);
        #1;
        chk("reset.count", DW'(count), 0);
        chk("reset.empty", DW'(empty), 1);
        chk("reset.full", DW'(full), 0);
        chk("reset.almost_empty", DW'(almost_empty), 1);
        chk("reset.almost_full", DW'(almost_full), 0);
        chk("reset.rd_valid", DW'(rd_valid), 0);
        chk("reset.rd_data", rd_data, 0);
        chk("reset.overflow", DW'(overflow), 0);
        chk("reset.underflow", DW'(underflow), 0);
        chk("reset.f_rd_valid", DW'(f_rd_valid), 0);
        chk("reset.f_empty", DW'(f_empty), 1);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-operation: underflow set, five words queued, then reset.
        step(mk(0, 0, 1, 0, 0, 0, 32'h22, 0, 1), "pre_rst_udf");
        for (int i = 0; i < 5; i++) step(mk(1, 32'h30 + i, 0, 0, i + 1, 0, 32'h22, 0, 1), $sformatf("pre_rst_wr%0d", i));
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.count", DW'(count), 0);
        chk("midrst.empty", DW'(empty), 1);
        chk("midrst.rd_valid", DW'(rd_valid), 0);
        chk("midrst.underflow", DW'(underflow), 0);
        chk("midrst.rd_data", rd_data, 0);
        rst_n = 1'b1;
        step(mk(1, 32'h40, 0, 0, 1, 0, 0, 0, 0), "post_rst_wr");
        step(mk(0, 0, 1, 0, 0, 1, 32'h40, 0, 0), "post_rst_rd");
        wr_en = 1'b0; rd_en = 1'b0;

        // FWFT instance: head word appears right after the write edge without rd_en.
        fstep(1, 32'hA5, 0);
        chk("fwft.rv_after_wr", DW'(f_rd_valid), 1);
        chk("fwft.data_after_wr", f_rd_data, 32'hA5);
        fstep(0, 0, 0);
        chk("fwft.data_held", f_rd_data, 32'hA5);
        fstep(0, 0, 1);
        chk("fwft.rv_after_pop", DW'(f_rd_valid), 0);
        chk("fwft.empty_after_pop", DW'(f_empty), 1);
        chk("fwft.underflow_clean", DW'(f_underflow), 0);
        fstep(1, 32'hB1, 0);
        fstep(1, 32'hB2, 0);
        chk("fwft.head_b1", f_rd_data, 32'hB1);
        chk("fwft.count2", DW'(f_count), 2);
        fstep(0, 0, 1);
        chk("fwft.head_b2", f_rd_data, 32'hB2);
        chk("fwft.rv_b2", DW'(f_rd_valid), 1);
        fstep(0, 0, 1);
        fstep(0, 0, 1);
        chk("fwft.underflow_set", DW'(f_underflow), 1);
        chk("fwft.count0", DW'(f_count), 0);
        f_rd_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
